// File: rtl/image_pixel_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : image_pixel_streamer_if
// Purpose  : BRAM read port plus pixel valid/ready stream for the streamer.
// Revision : 1.0 - initial release
// ============================================================================
interface image_pixel_streamer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic              bram_we;
    logic [DATA_W-1:0] bram_do;

    logic [DATA_W-1:0] pix_data;
    logic [ADDR_W-1:0] pix_idx;
    logic              pix_last;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output bram_addr, bram_en, bram_we,
        input  bram_do,
        output pix_data, pix_idx, pix_last, pix_valid,
        input  pix_ready
    );

    modport slave (
        input  bram_addr, bram_en, bram_we,
        output bram_do,
        input  pix_data, pix_idx, pix_last, pix_valid,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/image_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : image_pixel_streamer
// Purpose  : Scans the image BRAM and streams pixels through a 2-entry skid
//            buffer. Optional binarisation enabled by macro IMG_THRESH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module image_pixel_streamer #(
    parameter int PIXELS = 169,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
`ifdef IMG_THRESH_EN
    ,
    parameter logic [DATA_W-1:0] THRESH = 8'd128
`endif
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    output logic                   busy,
    output logic                   done,
    image_pixel_streamer_if.master bus
);

    localparam int                CNT_W       = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  c_pixels    = CNT_W'(PIXELS);
    localparam logic [CNT_W-1:0]  c_last_cnt  = CNT_W'(PIXELS - 1);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } entry_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_rd_addr;
    logic [ADDR_W-1:0] r_bram_addr;
    logic              r_bram_en;     // also marks the read in flight
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_occ;
    entry_t            r_head;
    entry_t            r_tail;

    logic              w_pop;
    logic [2:0]        w_pending_sum;
    logic              w_credit_ok;
    logic              w_issue;
    logic [DATA_W-1:0] w_cap_data;
    entry_t            w_cap;

`ifdef IMG_THRESH_EN
    assign w_cap_data = (bus.bram_do >= THRESH) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
`else
    assign w_cap_data = bus.bram_do;
`endif

    // The address register still holds the address of the read being captured.
    assign w_cap = {w_cap_data, r_bram_addr, (r_bram_addr == c_last_addr)};

    assign w_pop = (r_occ != 2'd0) && bus.pix_ready;

    // Credits count this cycle's pop so a full-rate stream keeps one read per cycle.
    assign w_pending_sum = {1'b0, r_occ} + {2'b00, r_bram_en} - {2'b00, w_pop};
    assign w_credit_ok   = (w_pending_sum < 3'd2);
    assign w_issue       = (r_state == S_STREAM) && (r_rd_addr < c_pixels) && w_credit_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= '0;
            r_bram_addr <= '0;
            r_bram_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_bram_en <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_STREAM;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_issue) begin
                        r_bram_addr <= r_rd_addr[ADDR_W-1:0];
                        r_bram_en   <= 1'b1;
                        r_rd_addr   <= r_rd_addr + 1'b1;
                        if (r_rd_addr == c_last_cnt) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && r_head.last) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({r_bram_en, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= w_cap;
                    end else begin
                        r_tail <= w_cap;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= w_cap;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_cap;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_occ_bound : assert property (@(posedge clk) disable iff (rst) (r_occ <= 2'd2));

    assign bus.bram_addr = r_bram_addr;
    assign bus.bram_en   = r_bram_en;
    assign bus.bram_we   = 1'b0;
    assign bus.pix_data  = r_head.data;
    assign bus.pix_idx   = r_head.idx;
    assign bus.pix_last  = r_head.last;
    assign bus.pix_valid = (r_occ != 2'd0);
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_image_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_pixel_streamer
// Purpose  : Self-checking bench with BRAM model, stream scoreboard and vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_pixel_streamer;

    localparam int PIXELS = 169;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    image_pixel_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    image_pixel_streamer #(.PIXELS(PIXELS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [0:255];
    always @(negedge clk) if (bus.bram_en) bus.bram_do <= mem[bus.bram_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_pix(input logic [7:0] raw);
`ifdef IMG_THRESH_EN
        return (raw >= 8'd128) ? 8'hFF : 8'h00;
`else
        return raw;
`endif
    endfunction

    // Scoreboard state: what the consumer has seen so far in the current image.
    int         start_cyc = 0;
    int         hs_count, rd_count, done_cnt, first_valid_rel, done_rel;
    bit         stalled;
    logic [17:0] prev_word;
    logic [7:0] hs_data [0:255];
    logic       hs_last_log [0:255];

    task automatic model_reset();
        hs_count = 0; rd_count = 0; done_cnt = 0;
        first_valid_rel = -1; done_rel = -1; stalled = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalled = 0;
        end else begin
            if (bus.bram_en) begin
                check("rd_order", 32'(bus.bram_addr), rd_count);
                rd_count++;
            end
            if (bus.pix_valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
            if (stalled)
                check("stall_stable", {14'd0, bus.pix_valid, bus.pix_last, bus.pix_idx, bus.pix_data},
                      {14'd0, prev_word});
            check("outstanding_le2", 32'((rd_count - hs_count) <= 2), 1);
            if (bus.pix_valid && bus.pix_ready) begin
                check("hs_idx", 32'(bus.pix_idx), hs_count);
                check("hs_data", 32'(bus.pix_data), 32'(exp_pix(mem[hs_count & 255])));
                check("hs_last", 32'(bus.pix_last), 32'(hs_count == PIXELS - 1));
                hs_data[hs_count & 255]     = bus.pix_data;
                hs_last_log[hs_count & 255] = bus.pix_last;
                hs_count++;
            end
            stalled   = bus.pix_valid && !bus.pix_ready;
            prev_word = {bus.pix_valid, bus.pix_last, bus.pix_idx, bus.pix_data};
            if (done) begin
                done_cnt++;
                done_rel = cyc - start_cyc + 1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; start_cyc = cyc;
    endtask

    task automatic run_to_done(input int budget, input bit rnd_ready);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            bus.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        check("done_within_budget", 32'(done_cnt != 0), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_image_done(input string tag);
        check({tag, "_handshakes"}, hs_count, PIXELS);
        check({tag, "_reads"}, rd_count, PIXELS);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_end"}, 32'(busy), 0);
    endtask

    typedef struct {
        int         addr;
        logic [7:0] raw;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;
    vec_t vecs [6];

    int  n;
    bit  p100, fin_hit;
    int  after;

    initial begin
        // Address/raw/expected-output vectors for the capture path.
`ifdef IMG_THRESH_EN
        vecs[0] = '{0, 8'd127, 8'h00, 1'b0};
        vecs[1] = '{1, 8'd128, 8'hFF, 1'b0};
        vecs[2] = '{2, 8'd255, 8'hFF, 1'b0};
        vecs[3] = '{3, 8'd0,   8'h00, 1'b0};
        vecs[4] = '{167, 8'd5,   8'h00, 1'b0};
        vecs[5] = '{168, 8'd200, 8'hFF, 1'b1};
`else
        vecs[0] = '{0, 8'd127, 8'd127, 1'b0};
        vecs[1] = '{1, 8'd128, 8'd128, 1'b0};
        vecs[2] = '{2, 8'd255, 8'd255, 1'b0};
        vecs[3] = '{3, 8'd0,   8'd0,   1'b0};
        vecs[4] = '{167, 8'd5,   8'd5,   1'b0};
        vecs[5] = '{168, 8'd200, 8'd200, 1'b1};
`endif
        bus.bram_do   = '0;
        bus.pix_ready = 1'b0;
        model_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bram_addr", 32'(bus.bram_addr), 0);
        check("rst_bram_en", 32'(bus.bram_en), 0);
        check("rst_bram_we", 32'(bus.bram_we), 0);
        check("rst_pix_data", 32'(bus.pix_data), 0);
        check("rst_pix_idx", 32'(bus.pix_idx), 0);
        check("rst_pix_last", 32'(bus.pix_last), 0);
        check("rst_pix_valid", 32'(bus.pix_valid), 0);
        @(posedge clk); #1; rst = 1'b0;

        // Full-rate image, ramp data
        model_reset();
        bus.pix_ready = 1'b1;
        pulse_start();
        check("s1_busy_after_start", 32'(busy), 1);
        run_to_done(400, 1'b0);
        check("s1_first_valid_cycle", first_valid_rel, 2);
        check("s1_done_cycle", done_rel, PIXELS + 3);
        check_image_done("s1");

        // Table vectors over random background data
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        foreach (vecs[k]) mem[vecs[k].addr] = vecs[k].raw;
        model_reset();
        pulse_start();
        run_to_done(400, 1'b0);
        check_image_done("vec");
        for (int k = 0; k < 6; k++) begin
            check($sformatf("vec%0d_data", k), 32'(hs_data[vecs[k].addr]), 32'(vecs[k].exp_data));
            check($sformatf("vec%0d_last", k), 32'(hs_last_log[vecs[k].addr]), 32'(vecs[k].exp_last));
        end

        // Random backpressure, random data
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        model_reset();
        pulse_start();
        run_to_done(3000, 1'b1);
        check_image_done("rnd");

        // Held backpressure: only two reads may be outstanding
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        model_reset();
        bus.pix_ready = 1'b0;
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        check("stall_reads", rd_count, 2);
        check("stall_bram_en", 32'(bus.bram_en), 0);
        check("stall_valid", 32'(bus.pix_valid), 1);
        check("stall_data", 32'(bus.pix_data), 0);
        check("stall_idx", 32'(bus.pix_idx), 0);
        run_to_done(400, 1'b0);
        check_image_done("stall");

        // Reset mid-stream after the 50th handshake
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        model_reset();
        pulse_start();
        n = 0;
        while (hs_count < 50 && n < 1000) begin
            @(posedge clk); #1;
            bus.pix_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("mid_reached_50", 32'(hs_count >= 50), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_bram_addr", 32'(bus.bram_addr), 0);
        check("mid_rst_bram_en", 32'(bus.bram_en), 0);
        check("mid_rst_pix_data", 32'(bus.pix_data), 0);
        check("mid_rst_pix_idx", 32'(bus.pix_idx), 0);
        check("mid_rst_pix_last", 32'(bus.pix_last), 0);
        check("mid_rst_pix_valid", 32'(bus.pix_valid), 0);
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_quiet_valid", 32'(bus.pix_valid), 0);
        check("post_rst_quiet_reads", rd_count, 0);
        check("post_rst_quiet_busy", 32'(busy), 0);
        pulse_start();
        run_to_done(3000, 1'b1);
        check_image_done("restart");

        // START re-pulsed mid-stream and during FIN is ignored
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        model_reset();
        bus.pix_ready = 1'b1;
        pulse_start();
        n = 0; after = 0; p100 = 0; fin_hit = 0;
        while (n < 600 && after < 6) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (fin_hit) after++;
            else if (done) begin start = 1'b1; fin_hit = 1; end
            if (!p100 && hs_count >= 100) begin start = 1'b1; p100 = 1; end
            n++;
        end
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("repulse_fin_seen", 32'(fin_hit), 1);
        check_image_done("repulse");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
